ifu_idu_buf: RTL and testbench

//   Two-entry elastic fetch buffer between IFU/instruction RAM and IDU; decouples fetch from decode.

---
 rtl/ifu_idu_buf.sv | 126 ++++++++++++
 tb/tb_ifu_idu_buf.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/ifu_idu_buf.sv
// Two-entry elastic fetch buffer between IFU and IDU, flushed by taken jumps from EXU.
// Optional perf counters (stall/flush) are built when IFU_IDU_BUF_PERF_EN is defined.
module ifu_idu_buf #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned INST_WIDTH = 32
`ifdef IFU_IDU_BUF_PERF_EN
  ,
  parameter int unsigned CNT_WIDTH  = 32
`endif
) (
  input  logic                  i_sys_clk,
  input  logic                  i_sys_rst,
  input  logic                  i_ifu_valid,
  output logic                  o_ifu_ready,
  input  logic [ADDR_WIDTH-1:0] i_ifu_pc,
  input  logic [ADDR_WIDTH-1:0] i_ifu_pc_next,
  input  logic [INST_WIDTH-1:0] i_ram_inst,
  input  logic                  i_exu_jmp_en,
`ifdef IFU_IDU_BUF_PERF_EN
  output logic [CNT_WIDTH-1:0]  o_buf_stall_cnt,
  output logic [CNT_WIDTH-1:0]  o_buf_flush_cnt,
`endif
  output logic                  o_idu_valid,
  input  logic                  i_idu_ready,
  output logic [ADDR_WIDTH-1:0] o_idu_pc,
  output logic [ADDR_WIDTH-1:0] o_idu_pc_next,
  output logic [INST_WIDTH-1:0] o_idu_inst
);

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] pc;
    logic [ADDR_WIDTH-1:0] pc_next;
    logic [INST_WIDTH-1:0] inst;
  } entry_t;

  // Occupancy doubles as the FSM state.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t state, state_nxt;
  logic   wr_ptr, wr_ptr_nxt;
  logic   rd_ptr, rd_ptr_nxt;
  logic   wr_en;
  logic   push, pop;
  entry_t mem [2];
  entry_t head;

  assign o_ifu_ready = (state != FULL);
  assign o_idu_valid = (state != EMPTY);

  assign push = i_ifu_valid & o_ifu_ready;
  assign pop  = o_idu_valid & i_idu_ready;

  assign head          = mem[rd_ptr];
  assign o_idu_pc      = head.pc;
  assign o_idu_pc_next = head.pc_next;
  assign o_idu_inst    = head.inst;

  // Next state; a flush discards everything, including a same-cycle push.
  always_comb begin
    state_nxt  = state;
    wr_ptr_nxt = wr_ptr;
    rd_ptr_nxt = rd_ptr;
    wr_en      = 1'b0;
    if (i_exu_jmp_en) begin
      state_nxt  = EMPTY;
      wr_ptr_nxt = 1'b0;
      rd_ptr_nxt = 1'b0;
    end else begin
      if (push) begin
        wr_en      = 1'b1;
        wr_ptr_nxt = ~wr_ptr;
      end
      if (pop) begin
        rd_ptr_nxt = ~rd_ptr;
      end
      case (state)
        EMPTY:   if (push) state_nxt = ONE;
        ONE: begin
          if (push && !pop)      state_nxt = FULL;
          else if (pop && !push) state_nxt = EMPTY;
        end
        FULL:    if (pop) state_nxt = ONE;
        default: state_nxt = EMPTY;
      endcase
    end
  end

  always_ff @(posedge i_sys_clk) begin
    if (i_sys_rst) begin
      state  <= EMPTY;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      mem[0] <= '0;
      mem[1] <= '0;
    end else begin
      state  <= state_nxt;
      wr_ptr <= wr_ptr_nxt;
      rd_ptr <= rd_ptr_nxt;
      if (wr_en) begin
        mem[wr_ptr] <= '{pc: i_ifu_pc, pc_next: i_ifu_pc_next, inst: i_ram_inst};
      end
    end
  end

`ifdef IFU_IDU_BUF_PERF_EN
  // Saturating perf counters; flushes of an empty buffer are not counted.
  always_ff @(posedge i_sys_clk) begin
    if (i_sys_rst) begin
      o_buf_stall_cnt <= '0;
      o_buf_flush_cnt <= '0;
    end else begin
      if (o_idu_valid && !i_idu_ready && (o_buf_stall_cnt != '1)) begin
        o_buf_stall_cnt <= o_buf_stall_cnt + CNT_WIDTH'(1);
      end
      if (i_exu_jmp_en && (state != EMPTY) && (o_buf_flush_cnt != '1)) begin
        o_buf_flush_cnt <= o_buf_flush_cnt + CNT_WIDTH'(1);
      end
    end
  end
`endif

endmodule

// File: tb/tb_ifu_idu_buf.sv
// Scoreboard bench for ifu_idu_buf: driver records accepted entries, negedge monitor checks IDU side.
// Build with +define+IFU_IDU_BUF_PERF_EN to include the perf counter checks.
module tb_ifu_idu_buf;

  localparam int unsigned AW = 32;
  localparam int unsigned IW = 32;
  localparam int unsigned CW = 32;

  typedef struct packed {
    logic [AW-1:0] pc;
    logic [AW-1:0] pc_next;
    logic [IW-1:0] inst;
  } ent_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          ifu_valid = 1'b0;
  logic          ifu_ready;
  logic [AW-1:0] ifu_pc = '0;
  logic [AW-1:0] ifu_pc_next = '0;
  logic [IW-1:0] ram_inst = '0;
  logic          jmp = 1'b0;
  logic          idu_valid;
  logic          idu_ready = 1'b0;
  logic [AW-1:0] idu_pc;
  logic [AW-1:0] idu_pc_next;
  logic [IW-1:0] idu_inst;
`ifdef IFU_IDU_BUF_PERF_EN
  logic [CW-1:0] stall_cnt;
  logic [CW-1:0] flush_cnt;
`endif

  int   errors = 0;
  int   checks = 0;
  int   delivered = 0;
  ent_t q[$];

  ifu_idu_buf dut (
    .i_sys_clk       (clk),
    .i_sys_rst       (rst),
    .i_ifu_valid     (ifu_valid),
    .o_ifu_ready     (ifu_ready),
    .i_ifu_pc        (ifu_pc),
    .i_ifu_pc_next   (ifu_pc_next),
    .i_ram_inst      (ram_inst),
    .i_exu_jmp_en    (jmp),
`ifdef IFU_IDU_BUF_PERF_EN
    .o_buf_stall_cnt (stall_cnt),
    .o_buf_flush_cnt (flush_cnt),
`endif
    .o_idu_valid     (idu_valid),
    .i_idu_ready     (idu_ready),
    .o_idu_pc        (idu_pc),
    .o_idu_pc_next   (idu_pc_next),
    .o_idu_inst      (idu_inst)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [AW-1:0] pc, input logic [IW-1:0] inst);
    ifu_valid   = v;
    ifu_pc      = pc;
    ifu_pc_next = pc + 32'd4;
    ram_inst    = inst;
  endtask

  // Monitor: sampled mid-cycle, describing the state before the coming edge.
  always @(negedge clk) begin
    if (!rst) begin
      check("sb_valid", 64'(idu_valid), 64'(q.size() != 0));
      check("sb_ready", 64'(ifu_ready), 64'(q.size() < 2));
      if (idu_valid && q.size() != 0) begin
        check("sb_pc",      64'(idu_pc),      64'(q[0].pc));
        check("sb_pc_next", 64'(idu_pc_next), 64'(q[0].pc_next));
        check("sb_inst",    64'(idu_inst),    64'(q[0].inst));
      end
    end
    if (rst || jmp) begin
      q.delete();
    end else begin
      if (idu_valid && idu_ready && q.size() != 0) begin
        void'(q.pop_front());
        delivered++;
      end
      if (ifu_valid && ifu_ready) begin
        q.push_back('{pc: ifu_pc, pc_next: ifu_pc_next, inst: ram_inst});
      end
    end
  end

  initial begin
    int base;

    // 1: reset values
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check("rst_valid", 64'(idu_valid), 64'd0);
    check("rst_ready", 64'(ifu_ready), 64'd1);
    check("rst_pc",    64'(idu_pc),    64'd0);
    check("rst_inst",  64'(idu_inst),  64'd0);

    // 2: single push, one-cycle latency
    idu_ready = 1'b1;
    drive(1'b1, 32'h8000_0000, 32'h0000_0013);
    step();
    drive(1'b0, '0, '0);
    check("t2_valid", 64'(idu_valid), 64'd1);
    check("t2_pc",    64'(idu_pc),    64'h8000_0000);
    check("t2_inst",  64'(idu_inst),  64'h0000_0013);
    step();
    check("t2_drain", 64'(idu_valid), 64'd0);

    // 3: back-pressure to FULL, third push held, then drain in order
    base = delivered;
    idu_ready = 1'b0;
    drive(1'b1, 32'h8000_0000, 32'h0010_0013);
    step();
    drive(1'b1, 32'h8000_0004, 32'h0020_0013);
    step();
    drive(1'b1, 32'h8000_0008, 32'h0030_0013);
    check("t3_full_ready", 64'(ifu_ready), 64'd0);
    repeat (3) step();
    check("t3_hold_pc",    64'(idu_pc),    64'h8000_0000);
    check("t3_hold_ready", 64'(ifu_ready), 64'd0);
    idu_ready = 1'b1;
    step();
    step();
    drive(1'b0, '0, '0);
    repeat (2) step();
    check("t3_count", 64'(delivered - base), 64'd3);
    check("t3_empty", 64'(idu_valid), 64'd0);

    // 4: flush while FULL with a concurrent upstream transfer
    rst = 1'b1;
    step();
    rst = 1'b0;
    idu_ready = 1'b0;
    drive(1'b1, 32'h8000_0040, 32'h0040_0013);
    step();
    drive(1'b1, 32'h8000_0044, 32'h0050_0013);
    step();
    drive(1'b1, 32'h8000_0100, 32'h0060_0013);
    jmp = 1'b1;
    step();
    jmp = 1'b0;
    drive(1'b0, '0, '0);
    check("t4_valid", 64'(idu_valid), 64'd0);
    check("t4_ready", 64'(ifu_ready), 64'd1);
    idu_ready = 1'b1;
    repeat (2) step();
    check("t4_dropped", 64'(idu_valid), 64'd0);
    jmp = 1'b1;
    step();
    jmp = 1'b0;
`ifdef IFU_IDU_BUF_PERF_EN
    check("t4_flush_cnt", 64'(flush_cnt), 64'd1);
`endif
    drive(1'b1, 32'h8000_0200, 32'h0070_0013);
    step();
    drive(1'b0, '0, '0);
    check("t4_post_pc", 64'(idu_pc), 64'h8000_0200);
    step();

    // 5: streaming push+pop, one entry per cycle
    base = delivered;
    idu_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 32'h8000_0000 + 32'(4 * i), 32'h0000_0013 + 32'(i << 20));
      step();
      check("t5_pc", 64'(idu_pc), 64'h8000_0000 + 64'(4 * i));
    end
    drive(1'b0, '0, '0);
    step();
    check("t5_count", 64'(delivered - base), 64'd10);

    // 7: reset mid-transfer drops entries and clears data
    idu_ready = 1'b0;
    drive(1'b1, 32'h8000_0300, 32'h0080_0013);
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    drive(1'b0, '0, '0);
    check("t7_valid", 64'(idu_valid), 64'd0);
    check("t7_pc",    64'(idu_pc),    64'd0);
    check("t7_ready", 64'(ifu_ready), 64'd1);

`ifdef IFU_IDU_BUF_PERF_EN
    // 6: stall counter
    check("t6_stall_rst", 64'(stall_cnt), 64'd0);
    drive(1'b1, 32'h8000_0400, 32'h0090_0013);
    step();
    drive(1'b0, '0, '0);
    repeat (5) step();
    check("t6_stall_cnt", 64'(stall_cnt), 64'd5);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("t6_stall_clr", 64'(stall_cnt), 64'd0);
    check("t6_flush_clr", 64'(flush_cnt), 64'd0);
`endif

    idu_ready = 1'b1;
    repeat (2) step();
    check("end_empty", 64'(q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
